// File: rtl/polyvec_matvec_sched.sv
// polyvec_matvec_sched: row/column sequencer driving the basemul-accumulate engine over a Kyber matrix-vector product
module polyvec_matvec_sched #(
  parameter int DEPTH = 8,
  parameter int KMAX  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       k_cfg,
  input  logic             transpose,
  input  logic             abort,
  output logic             acc_start,
  output logic             acc_clr,
  input  logic             acc_col_adv,
  input  logic             acc_done,
  output logic [DEPTH+2:0] base_a,
  output logic [DEPTH+2:0] base_b,
  output logic [1:0]       row,
  output logic [1:0]       col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, CLR, KICK, RUN, WAITLOW, DRAIN, FIN} state_t;
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_row, r_col, w_row_nxt, w_col_nxt;
  logic [2:0]       r_k, w_k_nxt, w_km1;
  logic             r_tr, w_tr_nxt, r_err, w_err_nxt, r_aclr;
  logic             w_k_ok, w_col_last, w_row_last;
  logic [3:0]       w_r4, w_c4, w_k4, w_idx;
  logic [DEPTH+2:0] r_base_a, r_base_b;
  assign w_km1      = r_k - 3'd1;
  assign w_k_ok     = (k_cfg >= 3'd2) && (k_cfg <= 3'(KMAX));
  assign w_col_last = {1'b0, r_col} == w_km1;
  assign w_row_last = {1'b0, r_row} == w_km1;
  assign w_r4       = {2'b00, r_row};
  assign w_c4       = {2'b00, r_col};
  assign w_k4       = {1'b0, r_k};
  assign w_idx      = r_tr ? w_c4 * w_k4 + w_r4 : w_r4 * w_k4 + w_c4;
  // Next-state logic; abort overrides everything outside IDLE and leaves err untouched
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_k_nxt     = r_k;
    w_tr_nxt    = r_tr;
    w_err_nxt   = r_err;
    if (abort && r_state != IDLE) w_state_nxt = IDLE;
    else case (r_state)
      IDLE: if (start) begin
        if (w_k_ok) begin
          w_k_nxt     = k_cfg;
          w_tr_nxt    = transpose;
          w_err_nxt   = 1'b0;
          w_row_nxt   = 2'd0;
          w_col_nxt   = 2'd0;
          w_state_nxt = CLR;
        end else w_err_nxt = 1'b1;
      end
      CLR:  w_state_nxt = KICK;
      KICK: w_state_nxt = RUN;
      RUN: begin
        if (acc_col_adv) begin
          if (w_col_last) w_err_nxt = 1'b1;
          else w_col_nxt = r_col + 2'd1;
        end
        if (acc_done) begin
          if ({1'b0, w_col_nxt} != w_km1) w_err_nxt = 1'b1;
          w_state_nxt = WAITLOW;
        end
      end
      WAITLOW: w_state_nxt = acc_done ? WAITLOW : DRAIN;
      DRAIN: if (out_ready) begin
        if (w_row_last) w_state_nxt = FIN;
        else begin
          w_row_nxt   = r_row + 2'd1;
          w_col_nxt   = 2'd0;
          w_state_nxt = CLR;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // Job registers; r_aclr gives the extra clear pulse that follows an abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row  <= 2'd0;
      r_col  <= 2'd0;
      r_k    <= 3'd2;
      r_tr   <= 1'b0;
      r_err  <= 1'b0;
      r_aclr <= 1'b0;
    end else begin
      r_row  <= w_row_nxt;
      r_col  <= w_col_nxt;
      r_k    <= w_k_nxt;
      r_tr   <= w_tr_nxt;
      r_err  <= w_err_nxt;
      r_aclr <= abort && r_state != IDLE;
    end
  end
  // Polynomial base addresses, one cycle behind row/col
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base_a <= '0;
      r_base_b <= '0;
    end else begin
      r_base_a <= {w_idx, {(DEPTH-1){1'b0}}};
      r_base_b <= {2'b00, r_col, {(DEPTH-1){1'b0}}};
    end
  end
  assign acc_clr   = (r_state == CLR) || r_aclr;
  assign acc_start = r_state == KICK;
  assign out_valid = r_state == DRAIN;
  assign busy      = r_state != IDLE;
  assign done      = r_state == FIN;
  assign err       = r_err;
  assign row       = r_row;
  assign col       = r_col;
  assign base_a    = r_base_a;
  assign base_b    = r_base_b;
endmodule
